// File: rtl/jts18_pri_sweep.sv
// Priority-permutation sweeper: drives W lanes out in one of W! orders, stepping
// through the orders in Lehmer sequence by frame-counted auto-run or button steps.
module jts18_pri_sweep #(
  parameter int W    = 5,
  parameter int VBLS = 180
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         LVBL,
  input  logic [1:0]   buttons,
  input  logic [7:0]   debug_bus,
  input  logic [W-1:0] busin,
  output logic [W-1:0] busout,
  output logic [9:0]   perm_idx,
  output logic         busy,
  output logic [7:0]   st_show
);

  function automatic int fact(input int n);
    int r;
    r = 1;
    for (int k = 2; k <= n; k++) r = r * k;
    return r;
  endfunction

  localparam int NPERM = fact(W);

  // Position of the n-th (0-based) lowest set bit of the free-lane pool.
  function automatic logic [2:0] sel_nth(input logic [W-1:0] pool, input logic [2:0] n);
    logic [2:0] cnt;
    logic [2:0] r;
    logic       found;
    cnt   = '0;
    r     = '0;
    found = 1'b0;
    for (int j = 0; j < W; j++) begin
      if (pool[j] && !found) begin
        if (cnt == n) begin
          r     = 3'(j);
          found = 1'b1;
        end else begin
          cnt = cnt + 3'd1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic lane(input logic [W-1:0] b, input logic [2:0] s);
    logic r;
    r = 1'b0;
    for (int j = 0; j < W; j++)
      if (s == 3'(j)) r = b[j];
    return r;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_DEC, S_COMMIT} state_t;

  state_t       state_q, state_d;
  logic [2:0]   c_q    [W];
  logic [2:0]   c_d    [W];
  logic [2:0]   map_q  [W];
  logic [2:0]   map_d  [W];
  logic [2:0]   nmap_q [W];
  logic [2:0]   nmap_d [W];
  logic [W-1:0] pool_q, pool_d;
  logic [2:0]   pos_q, pos_d;
  logic [9:0]   idx_q, idx_d;
  logic         run_q, run_d;
  logic         pend_q, pend_d;
  logic [7:0]   fcnt_q, fcnt_d;
  logic [1:0]   btn_l_q;
  logic         lvbl_l_q;
  logic [W-1:0] busout_q, busout_d;

  logic [1:0]   press;
  logic         clr, frame, frame_wrap, step_req, advance, carry;
  logic [2:0]   dig, sel;
  logic         dbg_unused;

  assign press      = btn_l_q & ~buttons;
  assign clr        = (buttons == 2'b00);
  assign frame      = ~lvbl_l_q & LVBL;
  assign frame_wrap = frame && (fcnt_q == 8'(VBLS - 1));
  assign step_req   = (press[1] & ~run_q) | (frame_wrap & run_q);
  assign dbg_unused = ^{debug_bus[7], debug_bus[5:1]};

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    map_d   = map_q;
    nmap_d  = nmap_q;
    pool_d  = pool_q;
    pos_d   = pos_q;
    idx_d   = idx_q;
    run_d   = run_q;
    pend_d  = pend_q;
    fcnt_d  = fcnt_q;
    advance = 1'b0;
    carry   = 1'b1;
    dig     = '0;
    sel     = '0;

    if (clr) begin
      state_d = S_IDLE;
      idx_d   = '0;
      run_d   = 1'b0;
      pend_d  = 1'b0;
      fcnt_d  = '0;
      pos_d   = '0;
      for (int k = 0; k < W; k++) begin
        c_d[k]   = '0;
        map_d[k] = 3'(k);
      end
    end else begin
      if (press[0]) run_d = ~run_q;
      if (frame) fcnt_d = frame_wrap ? 8'd0 : fcnt_q + 8'd1;

      if (state_q == S_IDLE && (step_req || pend_q)) begin
        advance = 1'b1;
        pend_d  = 1'b0;
      end else if (step_req) begin
        pend_d = 1'b1;
      end

      // Mixed-radix step: c[i] has radix W-i, the last digit is always zero.
      if (advance) begin
        for (int i = W - 2; i >= 0; i--) begin
          if (carry) begin
            if (!debug_bus[6]) begin
              if (c_q[i] == 3'(W - 1 - i)) c_d[i] = '0;
              else begin
                c_d[i] = c_q[i] + 3'd1;
                carry  = 1'b0;
              end
            end else begin
              if (c_q[i] == 3'd0) c_d[i] = 3'(W - 1 - i);
              else begin
                c_d[i] = c_q[i] - 3'd1;
                carry  = 1'b0;
              end
            end
          end
        end
        if (!debug_bus[6])
          idx_d = (idx_q == 10'(NPERM - 1)) ? 10'd0 : idx_q + 10'd1;
        else
          idx_d = (idx_q == 10'd0) ? 10'(NPERM - 1) : idx_q - 10'd1;
        state_d = S_DEC;
        pos_d   = '0;
        pool_d  = '1;
      end

      case (state_q)
        S_DEC: begin
          for (int k = 0; k < W; k++)
            if (pos_q == 3'(k)) dig = c_q[k];
          sel = sel_nth(pool_q, dig);
          for (int k = 0; k < W; k++) begin
            if (pos_q == 3'(k)) nmap_d[k] = sel;
            if (sel == 3'(k))   pool_d[k] = 1'b0;
          end
          if (pos_q == 3'(W - 1)) state_d = S_COMMIT;
          else                    pos_d   = pos_q + 3'd1;
        end
        S_COMMIT: begin
          map_d   = nmap_q;
          state_d = S_IDLE;
        end
        default: ;
      endcase
    end

    for (int i = 0; i < W; i++) busout_d[i] = lane(busin, map_q[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pos_q    <= '0;
      idx_q    <= '0;
      run_q    <= 1'b0;
      pend_q   <= 1'b0;
      fcnt_q   <= '0;
      btn_l_q  <= 2'b11;
      lvbl_l_q <= 1'b1;
      busout_q <= '0;
      for (int k = 0; k < W; k++) begin
        c_q[k]   <= '0;
        map_q[k] <= 3'(k);
      end
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      idx_q    <= idx_d;
      run_q    <= run_d;
      pend_q   <= pend_d;
      fcnt_q   <= fcnt_d;
      btn_l_q  <= buttons;
      lvbl_l_q <= LVBL;
      busout_q <= busout_d;
      c_q      <= c_d;
      map_q    <= map_d;
    end
  end

  // Decode scratch: only meaningful while a decode is in flight.
  always_ff @(posedge clk) begin
    nmap_q <= nmap_d;
    pool_q <= pool_d;
  end

  assign busout   = busout_q;
  assign perm_idx = idx_q;
  assign busy     = (state_q != S_IDLE);
  assign st_show  = debug_bus[0] ? {run_q, busy, pend_q, fcnt_q[4:0]} : idx_q[7:0];

endmodule

// File: tb/tb_jts18_pri_sweep.sv
// Bench for jts18_pri_sweep: three instances (W=3, 5, 6) share the control inputs.
module tb_jts18_pri_sweep;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, LVBL;
  logic [1:0] buttons;
  logic [7:0] debug_bus;
  logic [2:0] busin3, busout3;
  logic [4:0] busin5, busout5;
  logic [5:0] busin6, busout6;
  logic [9:0] idx3, idx5, idx6;
  logic       busy3, busy5, busy6;
  logic [7:0] st3, st5, st6;

  int checks = 0;
  int failures = 0;

  jts18_pri_sweep #(.W(3), .VBLS(2)) u3 (
    .clk(clk), .rst(rst), .LVBL(LVBL), .buttons(buttons), .debug_bus(debug_bus),
    .busin(busin3), .busout(busout3), .perm_idx(idx3), .busy(busy3), .st_show(st3));
  jts18_pri_sweep #(.W(5)) u5 (
    .clk(clk), .rst(rst), .LVBL(LVBL), .buttons(buttons), .debug_bus(debug_bus),
    .busin(busin5), .busout(busout5), .perm_idx(idx5), .busy(busy5), .st_show(st5));
  jts18_pri_sweep #(.W(6), .VBLS(2)) u6 (
    .clk(clk), .rst(rst), .LVBL(LVBL), .buttons(buttons), .debug_bus(debug_bus),
    .busin(busin6), .busout(busout6), .perm_idx(idx6), .busy(busy6), .st_show(st6));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int fact(input int n);
    int r;
    r = 1;
    for (int k = 2; k <= n; k++) r = r * k;
    return r;
  endfunction

  // Reference: factorial-base digits of idx pick lanes from a shrinking list.
  function automatic logic [17:0] model_map(input int w, input int idx);
    int pool[$];
    int rem, f, d;
    logic [17:0] m;
    m = '0;
    for (int j = 0; j < w; j++) pool.push_back(j);
    rem = idx;
    for (int i = 0; i < w; i++) begin
      f   = fact(w - 1 - i);
      d   = rem / f;
      rem = rem % f;
      m[3*i +: 3] = 3'(pool[d]);
      pool.delete(d);
    end
    return m;
  endfunction

  function automatic logic [7:0] apply_map(input int w, input logic [17:0] m, input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = b[m[3*i +: 3]];
    return r;
  endfunction

  function automatic logic [17:0] pk(input int a, input int b, input int c);
    return {9'd0, 3'(c), 3'(b), 3'(a)};
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      3:       return busy3;
      5:       return busy5;
      default: return busy6;
    endcase
  endfunction

  function automatic logic [7:0] get_out(input int w);
    case (w)
      3:       return 8'(busout3);
      5:       return 8'(busout5);
      default: return 8'(busout6);
    endcase
  endfunction

  task automatic set_busin(input int w, input logic [7:0] v);
    case (w)
      3:       busin3 = v[2:0];
      5:       busin5 = v[4:0];
      default: busin6 = v[5:0];
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1; buttons = 2'b11; LVBL = 1'b1; debug_bus = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input int b);
    @(negedge clk);
    buttons[b] = 1'b0;
    @(negedge clk);
    buttons[b] = 1'b1;
  endtask

  task automatic wait_idle(input int w);
    int n;
    n = 0;
    while (get_busy(w) && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) chk("busy_timeout", 1, 0);
  endtask

  // Press step, count busy cycles, return once busout reflects the new map.
  task automatic do_step(input int w, output int nb);
    nb = 0;
    press(1);
    while (get_busy(w) && nb < 40) begin
      nb++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic check_map(input int w, input logic [17:0] m);
    logic [7:0] b;
    for (int j = 0; j < w; j++) begin
      b = 8'(1 << j);
      set_busin(w, b);
      @(negedge clk);
      chk("map_lane", get_out(w), apply_map(w, m, b));
    end
  endtask

  task automatic frame();
    @(negedge clk) LVBL = 1'b0;
    repeat (3) @(negedge clk);
    LVBL = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    int          idx;
    logic [17:0] map;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int nb, bad, midx, dir;
    logic [17:0] rec;
    logic [7:0]  o, b;
    bit seen[logic [17:0]];

    tbl[0] = '{1, pk(0, 2, 1)};
    tbl[1] = '{2, pk(1, 0, 2)};
    tbl[2] = '{3, pk(1, 2, 0)};
    tbl[3] = '{4, pk(2, 0, 1)};
    tbl[4] = '{5, pk(2, 1, 0)};
    tbl[5] = '{0, pk(0, 1, 2)};

    rst = 1'b1; LVBL = 1'b1; buttons = 2'b11; debug_bus = 8'h00;
    busin3 = '0; busin6 = '0; busin5 = 5'b00001;

    // Reset values, then idle hold with no events.
    repeat (3) @(negedge clk);
    chk("rst_busout", busout5, 0);
    chk("rst_idx", idx5, 0);
    chk("rst_busy", busy5, 0);
    chk("rst_st_show", st5, 0);
    rst = 1'b0;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (busout5 != 5'b00001 || idx5 != 0 || busy5 != 1'b0) bad++;
    end
    chk("idle_hold_bad_cycles", bad, 0);

    // W=3 table: six up-steps.
    do_reset();
    check_map(3, pk(0, 1, 2));
    for (int k = 0; k < 6; k++) begin
      do_step(3, nb);
      chk("busy_len", nb, 4);
      chk("tbl_idx", idx3, tbl[k].idx);
      check_map(3, tbl[k].map);
    end

    // W=3 down with a pending request.
    do_reset();
    debug_bus = 8'h41;
    busin3 = 3'b011;
    press(1);
    chk("down_idx", idx3, 5);
    press(1);
    chk("pend_set", st3[5], 1);
    chk("pend_idx_hold", idx3, 5);
    wait_idle(3);
    @(negedge clk);
    chk("map210_out", busout3, apply_map(3, pk(2, 1, 0), 8'b011));
    chk("pend_restart_busy", busy3, 1);
    chk("pend_restart_idx", idx3, 4);
    wait_idle(3);
    @(negedge clk);
    chk("pend_final_idx", idx3, 4);
    chk("pend_clear", st3[5], 0);
    check_map(3, pk(2, 0, 1));

    // Auto-run, VBLS=2.
    do_reset();
    debug_bus = 8'h01;
    press(0);
    chk("run_on", st3[7], 1);
    repeat (6) frame();
    chk("auto_idx3", idx3, 3);
    chk("auto_idx6", idx6, 3);
    press(0);
    chk("run_off", st3[7], 0);
    repeat (4) frame();
    chk("stopped_idx3", idx3, 3);

    // Clear mid-decode.
    do_reset();
    busin3 = 3'b011;
    repeat (3) do_step(3, nb);
    chk("pre_clr_idx", idx3, 3);
    debug_bus = 8'h01;
    press(0);
    frame();
    @(negedge clk) LVBL = 1'b0;
    repeat (2) @(negedge clk);
    LVBL = 1'b1;
    @(negedge clk);
    chk("clr_pre_idx", idx3, 4);
    chk("clr_pre_busy", busy3, 1);
    buttons = 2'b00;
    @(negedge clk);
    chk("clr_idx", idx3, 0);
    chk("clr_busy", busy3, 0);
    chk("clr_run", st3[7], 0);
    buttons = 2'b11;
    @(negedge clk);
    chk("clr_busout", busout3, busin3);

    // W=6 full sweep.
    do_reset();
    for (int s = 1; s <= 720; s++) begin
      do_step(6, nb);
      midx = s % 720;
      chk("sweep_idx", idx6, midx);
      rec = '0;
      for (int j = 0; j < 6; j++) begin
        busin6 = 6'(1 << j);
        @(negedge clk);
        o = 8'(busout6);
        chk("sweep_onehot", $countones(o), 1);
        for (int i = 0; i < 6; i++) if (o[i]) rec[3*i +: 3] = 3'(j);
      end
      chk("sweep_map", rec, model_map(6, midx));
      seen[rec] = 1'b1;
    end
    chk("sweep_unique", seen.num(), 720);
    chk("sweep_wrap", idx6, 0);

    // W=5 random walk, random lanes.
    do_reset();
    midx = 0;
    repeat (80) begin
      dir = $urandom_range(0, 1);
      debug_bus[6] = dir[0];
      do_step(5, nb);
      midx = dir[0] ? (midx + 119) % 120 : (midx + 1) % 120;
      chk("rand_idx", idx5, midx);
      repeat (3) begin
        b = 8'($urandom_range(0, 31));
        busin5 = b[4:0];
        @(negedge clk);
        chk("rand_busout", busout5, apply_map(5, model_map(5, midx), b));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
